// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
package ram_arb_pkg;

    // Arbitration FSM encoding; the top keeps its state in plain logic [1:0].
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // Requester identity: 0 = AXI user port, 1 = local engine.
    typedef logic port_id_t;

    // One in-flight read tag.
    typedef struct packed {
        logic     valid;
        port_id_t id;
    } tag_t;

    localparam int unsigned BS_DEFAULT = 4;
    localparam int unsigned BSW        = $clog2(BS_DEFAULT);

    // Byte-offset width for an arbitrary bytes-per-word value.
    function automatic int unsigned byte_off_w(input int unsigned bs);
        return (bs <= 1) ? 0 : $clog2(bs);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side request/response bundle for one arbiter port.
interface ram_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BS = 4
) ();

    logic          valid;
    logic          ready;
    logic [AW-1:0] a;
    logic [BS-1:0] we;
    logic [DW-1:0] d;
    logic          lock;
    logic          rvalid;
    logic [DW-1:0] q;

    modport master (
        output valid, a, we, d, lock,
        input  ready, rvalid, q
    );

    modport slave (
        input  valid, a, we, d, lock,
        output ready, rvalid, q
    );

endinterface

// File: rtl/ram_rd_tag_pipe.sv
// Shift register tracking which port issued each in-flight read.
module ram_rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output tag_t pre_o,
    output tag_t out_o
);

    tag_t stage_q [Depth];

    // Advance tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // pre_o lines up with RAM_Q being valid; out_o with the registered response.
    assign pre_o = stage_q[Depth-2];
    assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one single-port RAM.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned BS       = 4,
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              usr_clk,
    input  logic              usr_reset_n,
    ram_port_arbiter_if.slave m0,
    ram_port_arbiter_if.slave m1,
    output logic              RAM_CEN,
    output logic [BS-1:0]     RAM_WEN,
    output logic [RAM_AW-1:0] RAM_A,
    output logic [DW-1:0]     RAM_D,
    input  logic [DW-1:0]     RAM_Q
);

    localparam int unsigned ByteOffW = byte_off_w(BS);
    localparam int unsigned CntW     = $clog2(LOCK_MAX + 1);

    localparam logic [CntW-1:0] MaxCnt = CntW'(LOCK_MAX);
    localparam logic [CntW-1:0] OneCnt = CntW'(1);

    localparam logic [1:0] StArb   = ARB;
    localparam logic [1:0] StLock0 = LOCK0;
    localparam logic [1:0] StLock1 = LOCK1;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    port_id_t        rr_q, rr_d;   // port preferred on the next tie

    logic            gnt_valid;
    port_id_t        gnt_id;
    logic [AW-1:0]   gnt_a;
    logic [BS-1:0]   gnt_we;
    logic [DW-1:0]   gnt_d;
    logic            gnt_lock;

    port_id_t        owner;
    logic            own_valid, own_lock;
    logic            oth_valid, oth_lock;

    logic              ram_cen_q;
    logic [BS-1:0]     ram_wen_q;
    logic [RAM_AW-1:0] ram_a_q;
    logic [DW-1:0]     ram_d_q;
    logic [DW-1:0]     q0_q, q1_q;

    tag_t tag_in, tag_pre, tag_out;

    // Bits outside the word-address window are intentionally dropped.
    logic addr_unused;
    assign addr_unused = ^gnt_a;

    // Owner/other view of the request lines while a lock is held.
    always_comb begin
        owner     = (state_q == StLock1);
        own_valid = owner ? m1.valid : m0.valid;
        own_lock  = owner ? m1.lock  : m0.lock;
        oth_valid = owner ? m0.valid : m1.valid;
        oth_lock  = owner ? m0.lock  : m1.lock;
    end

    // Request fields of whichever port wins this cycle.
    always_comb begin
        gnt_a    = gnt_id ? m1.a    : m0.a;
        gnt_we   = gnt_id ? m1.we   : m0.we;
        gnt_d    = gnt_id ? m1.d    : m0.d;
        gnt_lock = gnt_id ? m1.lock : m0.lock;
    end

    // Grant decision and next FSM / lock counter / round-robin state.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;

        case (state_q)
            StLock0, StLock1: begin
                if ((cnt_q == MaxCnt) && oth_valid) begin
                    // Lock budget spent: the waiting port gets in regardless.
                    gnt_valid = 1'b1;
                    gnt_id    = ~owner;
                    rr_d      = owner;
                    if (oth_lock) begin
                        state_d = owner ? StLock0 : StLock1;
                        cnt_d   = OneCnt;
                    end else begin
                        state_d = StArb;
                        cnt_d   = '0;
                    end
                end else if (own_valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = owner;
                    rr_d      = ~owner;
                    if (own_lock) begin
                        cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        state_d = StArb;
                        cnt_d   = '0;
                    end
                end else begin
                    // Owner went idle: lock released, other port may slip in.
                    state_d = StArb;
                    cnt_d   = '0;
                    if (oth_valid) begin
                        gnt_valid = 1'b1;
                        gnt_id    = ~owner;
                        rr_d      = owner;
                    end
                end
            end
            default: begin
                if (m0.valid || m1.valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = (m0.valid && m1.valid) ? rr_q : m1.valid;
                end
                if (gnt_valid) begin
                    rr_d = ~gnt_id;
                    if (gnt_lock) begin
                        state_d = gnt_id ? StLock1 : StLock0;
                        cnt_d   = OneCnt;
                    end
                end
            end
        endcase
    end

    assign m0.ready = gnt_valid && (gnt_id == 1'b0);
    assign m1.ready = gnt_valid && (gnt_id == 1'b1);

    // Arbitration state registers.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_q <= StArb;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Register the granted access onto the active-low RAM pins.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            ram_cen_q <= 1'b1;
            ram_wen_q <= '1;
            ram_a_q   <= '0;
            ram_d_q   <= '0;
        end else if (gnt_valid) begin
            ram_cen_q <= 1'b0;
            ram_wen_q <= ~gnt_we;
            ram_a_q   <= gnt_a[ByteOffW +: RAM_AW];
            ram_d_q   <= gnt_d;
        end else begin
            ram_cen_q <= 1'b1;
            ram_wen_q <= '1;
        end
    end

    assign RAM_CEN = ram_cen_q;
    assign RAM_WEN = ram_wen_q;
    assign RAM_A   = ram_a_q;
    assign RAM_D   = ram_d_q;

    assign tag_in.valid = gnt_valid && (gnt_we == '0);
    assign tag_in.id    = gnt_id;

    ram_rd_tag_pipe #(
        .Depth (RD_LAT + 1)
    ) u_tag_pipe (
        .clk_i  (usr_clk),
        .rst_ni (usr_reset_n),
        .tag_i  (tag_in),
        .pre_o  (tag_pre),
        .out_o  (tag_out)
    );

    // Capture RAM_Q into the issuing port's data register only.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            q0_q <= '0;
            q1_q <= '0;
        end else if (tag_pre.valid) begin
            if (tag_pre.id) begin
                q1_q <= RAM_Q;
            end else begin
                q0_q <= RAM_Q;
            end
        end
    end

    assign m0.q      = q0_q;
    assign m1.q      = q1_q;
    assign m0.rvalid = tag_out.valid && (tag_out.id == 1'b0);
    assign m1.rvalid = tag_out.valid && (tag_out.id == 1'b1);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a one-cycle sync RAM model.
module tb_ram_port_arbiter;

    logic        usr_clk;
    logic        usr_reset_n;
    logic        ram_cen;
    logic [3:0]  ram_wen;
    logic [9:0]  ram_a;
    logic [31:0] ram_d;
    logic [31:0] ram_q;

    int n_checks;
    int n_fail;

    ram_port_arbiter_if #(.AW(32), .DW(32), .BS(4)) m0_if ();
    ram_port_arbiter_if #(.AW(32), .DW(32), .BS(4)) m1_if ();

    ram_port_arbiter #(
        .AW       (32),
        .DW       (32),
        .BS       (4),
        .RAM_AW   (10),
        .RD_LAT   (2),
        .LOCK_MAX (16)
    ) dut (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .RAM_CEN     (ram_cen),
        .RAM_WEN     (ram_wen),
        .RAM_A       (ram_a),
        .RAM_D       (ram_d),
        .RAM_Q       (ram_q)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    // RAM model: samples pins at the edge closing the access cycle, Q valid next cycle.
    logic [31:0] mem [1024];
    logic [31:0] ram_q1;
    logic        pre_we;
    logic [9:0]  pre_a;
    logic [31:0] pre_d;

    always @(posedge usr_clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (!ram_cen) begin
            for (int b = 0; b < 4; b++) begin
                if (!ram_wen[b]) mem[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
            end
            ram_q1 <= mem[ram_a];
        end
    end
    assign ram_q = ram_q1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic idle_ports();
        m0_if.valid = 1'b0; m0_if.a = '0; m0_if.we = '0; m0_if.d = '0; m0_if.lock = 1'b0;
        m1_if.valid = 1'b0; m1_if.a = '0; m1_if.we = '0; m1_if.d = '0; m1_if.lock = 1'b0;
    endtask

    task automatic pulse_reset();
        usr_reset_n = 1'b0;
        tick();
        usr_reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        usr_reset_n = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        idle_ports();
        repeat (2) tick();

        // Preload RAM while the DUT holds CEN high.
        pre_we = 1'b1; pre_a = 10'd4; pre_d = 32'h1234_5678;
        tick();
        pre_a = 10'd2; pre_d = 32'h0;
        tick();
        pre_we = 1'b0;

        // Reset values.
        check_eq("rst_cen", 64'(ram_cen), 64'd1);
        check_eq("rst_wen", 64'(ram_wen), 64'hF);
        check_eq("rst_a", 64'(ram_a), 64'd0);
        check_eq("rst_d", 64'(ram_d), 64'd0);
        check_eq("rst_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        check_eq("rst_q", 64'(m0_if.q | m1_if.q), 64'd0);
        check_eq("rst_ready", 64'({m0_if.ready, m1_if.ready}), 64'd0);
        usr_reset_n = 1'b1;
        tick();

        // Single read from m1.
        m1_if.valid = 1'b1; m1_if.a = 32'h10;
        #1;
        check_eq("rd_m1_ready", 64'(m1_if.ready), 64'd1);
        check_eq("rd_m0_ready", 64'(m0_if.ready), 64'd0);
        tick();
        m1_if.valid = 1'b0;
        check_eq("rd_cen", 64'(ram_cen), 64'd0);
        check_eq("rd_a", 64'(ram_a), 64'd4);
        check_eq("rd_wen", 64'(ram_wen), 64'hF);
        tick();
        check_eq("rd_cen_idle", 64'(ram_cen), 64'd1);
        check_eq("rd_early_rvalid", 64'(m1_if.rvalid), 64'd0);
        tick();
        check_eq("rd_m1_rvalid", 64'(m1_if.rvalid), 64'd1);
        check_eq("rd_m1_q", 64'(m1_if.q), 64'h1234_5678);
        check_eq("rd_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
        tick();
        check_eq("rd_rvalid_one_cycle", 64'(m1_if.rvalid), 64'd0);

        // Contention without lock: alternate starting from m0 after reset.
        pulse_reset();
        m0_if.valid = 1'b1; m0_if.a = 32'h0;
        m1_if.valid = 1'b1; m1_if.a = 32'h4;
        #1;
        for (int i = 0; i < 6; i++) begin
            check_eq("rr_m0_ready", 64'(m0_if.ready), 64'(i % 2 == 0));
            check_eq("rr_m1_ready", 64'(m1_if.ready), 64'(i % 2 == 1));
            tick();
            check_eq("rr_cen", 64'(ram_cen), 64'd0);
            check_eq("rr_a", 64'(ram_a), 64'(i % 2));
        end
        idle_ports();
        repeat (4) tick();

        // Lock burst: four m0 writes hold off a waiting m1.
        m1_if.valid = 1'b1; m1_if.a = 32'h40; m1_if.we = 4'hF; m1_if.d = 32'h5555_5555;
        m0_if.valid = 1'b1; m0_if.we = 4'hF;
        for (int i = 0; i < 4; i++) begin
            m0_if.a = 32'h30 + 32'(4 * i);
            m0_if.d = 32'(i);
            m0_if.lock = (i < 3);
            #1;
            check_eq("lk_m0_ready", 64'(m0_if.ready), 64'd1);
            check_eq("lk_m1_ready", 64'(m1_if.ready), 64'd0);
            tick();
            check_eq("lk_wen", 64'(ram_wen), 64'h0);
            check_eq("lk_a", 64'(ram_a), 64'(12 + i));
        end
        m0_if.valid = 1'b0; m0_if.lock = 1'b0;
        #1;
        check_eq("lk_m1_after", 64'(m1_if.ready), 64'd1);
        tick();
        m1_if.valid = 1'b0;
        check_eq("lk_m1_a", 64'(ram_a), 64'h10);
        check_eq("lk_m1_d", 64'(ram_d), 64'h5555_5555);
        idle_ports();
        tick();

        // Lock bound: m1 breaks in on the 17th cycle, then m0 regains the port.
        m0_if.valid = 1'b1; m0_if.lock = 1'b1; m0_if.a = 32'h0;
        m1_if.valid = 1'b1; m1_if.lock = 1'b0; m1_if.a = 32'h4;
        #1;
        for (int c = 1; c <= 20; c++) begin
            check_eq("lb_m0_ready", 64'(m0_if.ready), 64'(c != 17));
            check_eq("lb_m1_ready", 64'(m1_if.ready), 64'(c == 17));
            tick();
        end
        idle_ports();
        repeat (5) tick();

        // Byte write then read with truncated upper address bits.
        m0_if.valid = 1'b1; m0_if.a = 32'h8; m0_if.we = 4'b0010; m0_if.d = 32'hAABB_CCDD;
        #1;
        check_eq("bw_ready", 64'(m0_if.ready), 64'd1);
        tick();
        m0_if.a = 32'hABC0_0008; m0_if.we = 4'b0000; m0_if.d = 32'h0;
        check_eq("bw_wen", 64'(ram_wen), 64'hD);
        check_eq("bw_a", 64'(ram_a), 64'd2);
        check_eq("bw_d", 64'(ram_d), 64'hAABB_CCDD);
        #1;
        check_eq("br_ready", 64'(m0_if.ready), 64'd1);
        tick();
        m0_if.valid = 1'b0;
        check_eq("br_a_trunc", 64'(ram_a), 64'd2);
        check_eq("br_wen", 64'(ram_wen), 64'hF);
        tick();
        check_eq("br_early_rvalid", 64'(m0_if.rvalid), 64'd0);
        tick();
        check_eq("br_rvalid", 64'(m0_if.rvalid), 64'd1);
        check_eq("br_q", 64'(m0_if.q), 64'h0000_CC00);
        check_eq("br_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
        idle_ports();
        repeat (2) tick();

        // Reset one cycle after a read is accepted.
        m1_if.valid = 1'b1; m1_if.a = 32'h10;
        #1;
        check_eq("mr_ready", 64'(m1_if.ready), 64'd1);
        tick();
        m1_if.valid = 1'b0;
        usr_reset_n = 1'b0;
        #1;
        check_eq("mr_cen", 64'(ram_cen), 64'd1);
        check_eq("mr_wen", 64'(ram_wen), 64'hF);
        check_eq("mr_a", 64'(ram_a), 64'd0);
        check_eq("mr_d", 64'(ram_d), 64'd0);
        check_eq("mr_q", 64'(m0_if.q | m1_if.q), 64'd0);
        tick();
        usr_reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("mr_no_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
